// File: rtl/pin_entry_terminal.sv
// Keypad PIN terminal: collects four BCD digits, strobes the code to the gate
// controller and reports its verdict. Optional inter-digit timeout via KEYPAD_TIMEOUT_EN.
module pin_entry_terminal #(
    parameter int RESP_TIMEOUT  = 16,
    parameter int DIGIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_clear,
    input  logic        key_enter,
    input  logic        open_gate,
    input  logic        wrong_pin,
    input  logic        blocked_gate,
    output logic [15:0] code,
    output logic        code_valid,
    output logic [2:0]  digit_count,
    output logic        entry_locked,
    output logic        key_error,
    output logic        accepted,
    output logic        rejected,
    output logic        resp_timeout
);

    localparam int TMAX = (RESP_TIMEOUT > DIGIT_TIMEOUT) ? RESP_TIMEOUT : DIGIT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT    = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_code, w_code_nxt;
    logic [2:0]    r_cnt, w_cnt_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_err, r_acc, r_rej, r_to;
    logic          w_err_nxt, w_acc_nxt, w_rej_nxt, w_to_nxt;
    logic          w_digit_ok;

    assign w_digit_ok = (key_digit <= 4'd9);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_code  <= 16'h0000;
            r_cnt   <= 3'd0;
            r_timer <= '0;
            r_err   <= 1'b0;
            r_acc   <= 1'b0;
            r_rej   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
            r_err   <= w_err_nxt;
            r_acc   <= w_acc_nxt;
            r_rej   <= w_rej_nxt;
            r_to    <= w_to_nxt;
        end
    end

    // Timer is shared: response wait in WAIT, inter-digit inactivity in COLLECT.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = '0;
        w_err_nxt   = 1'b0;
        w_acc_nxt   = 1'b0;
        w_rej_nxt   = 1'b0;
        w_to_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_clear) begin
                    w_code_nxt = 16'h0000;
                end else if (key_enter) begin
                    w_err_nxt = 1'b1;
                end else if (key_valid) begin
                    if (w_digit_ok) begin
                        w_code_nxt  = {12'h000, key_digit};
                        w_cnt_nxt   = 3'd1;
                        w_state_nxt = S_COLLECT;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
`ifdef KEYPAD_TIMEOUT_EN
                w_timer_nxt = (key_valid || key_clear || key_enter) ? '0 : r_timer + TW'(1);
`endif
                if (key_clear) begin
                    w_code_nxt  = 16'h0000;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = S_IDLE;
                end else if (key_enter) begin
                    if (r_cnt == 3'd4) w_state_nxt = S_SEND;
                    else               w_err_nxt   = 1'b1;
                end else if (key_valid) begin
                    if (w_digit_ok && r_cnt != 3'd4) begin
                        w_code_nxt = {r_code[11:0], key_digit};
                        w_cnt_nxt  = r_cnt + 3'd1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
`ifdef KEYPAD_TIMEOUT_EN
                else if (r_timer == TW'(DIGIT_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = 16'h0000;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            S_SEND: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + TW'(1);
                if (blocked_gate) begin
                    w_code_nxt  = 16'h0000;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = S_LOCKED;
                end else if (open_gate || wrong_pin || r_timer == TW'(RESP_TIMEOUT - 1)) begin
                    // A verdict in the expiry cycle takes precedence over the timeout.
                    w_acc_nxt   = open_gate;
                    w_rej_nxt   = !open_gate && wrong_pin;
                    w_to_nxt    = !open_gate && !wrong_pin;
                    w_code_nxt  = 16'h0000;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOCKED: begin
                w_code_nxt = 16'h0000;
                w_cnt_nxt  = 3'd0;
                if (!blocked_gate) w_state_nxt = S_IDLE;
            end
            default: begin
                w_code_nxt  = 16'h0000;
                w_cnt_nxt   = 3'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        code         = r_code;
        digit_count  = r_cnt;
        code_valid   = (r_state == S_SEND);
        entry_locked = (r_state == S_LOCKED);
        key_error    = r_err;
        accepted     = r_acc;
        rejected     = r_rej;
        resp_timeout = r_to;
    end

endmodule
